ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 keyboard receiver running in the system clock domain. Synchronises and deglitches the raw PS2_KBCLK/PS2_KBDAT pins, deframes 11-bit PS/2 frames with start/parity/stop checking and an inter-edge timeout, and buffers each accepted byte in a FIFO with a valid/ready output. Also keeps an N-byte scan-code history vector for the display/decoder logic downstream.

## Interface
Parameters:
- CODE_BYTES, 2, bytes held in code_vector history (≥1)
- FIFO_DEPTH, 4, byte FIFO entries (power of two, ≥2)
- FILTER_LEN, 4, consecutive equal samples before a filtered pin changes (≥1)
- TIMEOUT_CYCLES, 50000, clk cycles without a filtered falling edge mid-frame before abort (≥16)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- PS2_KBCLK  in  1  raw PS/2 clock pin, asynchronous
- PS2_KBDAT  in  1  raw PS/2 data pin, asynchronous
- code_vector  out  8*CODE_BYTES  history of accepted bytes, newest in bits [7:0]
- byte_data  out  8  FIFO head byte
- byte_valid  out  1  FIFO non-empty
- byte_ready  in  1  consumer pop; pop when byte_valid && byte_ready
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries
- frame_err  out  1  one-cycle pulse: bad start, bad stop or timeout
- parity_err  out  1  one-cycle pulse: odd-parity failure
- overflow  out  1  one-cycle pulse: accepted byte dropped, FIFO full

## Operation
- Each pin: 2-FF synchroniser, then filter; filtered output takes new value after FILTER_LEN consecutive identical synchronised samples. Filtered values reset to 1.
- Sample event: filtered clock 1→0 (one-cycle strobe); data sampled is filtered data in that cycle.
- FSM states IDLE, DATA, PARITY, STOP; bit counter 0..7.
- IDLE: event with data 0 → DATA, counter 0; event with data 1 → frame_err pulse, stay IDLE.
- DATA: shift data in LSB-first; after 8th bit → PARITY.
- PARITY: store bit → STOP.
- STOP: on event always → IDLE. Stop bit 0 → frame_err, byte dropped. Else XOR of 8 data bits and parity bit 0 → parity_err, byte dropped. Else byte accepted.
- Accepted byte: code_vector <= {code_vector[8*CODE_BYTES-9:0], byte} (CODE_BYTES=1: replaced); pushed to FIFO unless full.
- Full FIFO: push rejected, overflow pulse, code_vector still updated. Full with pop same cycle: pop and push both occur, no overflow.
- Timeout: counter cleared on every event; in non-IDLE states it counts; reaching TIMEOUT_CYCLES-1 → IDLE, frame_err pulse, partial byte discarded. Counter held 0 in IDLE.
- Error pulses are mutually exclusive per frame; at most one per cycle.

## Timing
- Reset: state IDLE, code_vector 0, FIFO empty, byte_valid 0, byte_data 0, fifo_count 0, all pulses 0, filtered pins 1.
- Pin falling edge to sample event: 2 sync + FILTER_LEN cycles.
- Stop-bit event to byte_valid/code_vector/pulses: 1 cycle (registered).
- byte_data valid in same cycle byte_valid is high; stable until popped.
- Pop takes effect on the clk edge where byte_valid && byte_ready; byte_ready ignored when empty.
- Reset mid-frame: frame discarded, no pulses in reset-release cycle.

## Structure
- Package ps2_pkg: state enum (IDLE, DATA, PARITY, STOP), START_BIT=0, STOP_BIT=1, ODD_PARITY=1.
- Sub-module ps2_sync_filter (sync + filter, parameter FILTER_LEN), instantiated for clock and data. FIFO inline (circular buffer, pointers one bit wider than address).

## Test plan
- Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1 start→stop, parity 0) -> byte_valid, byte_data 0x1C, code_vector[7:0]=0x1C, no pulses.
- Frames 0xF0 (parity 1), 0x1C with byte_ready=0 -> fifo_count 2, code_vector 0xF01C; pops return 0xF0 then 0x1C.
- 0x1C with parity bit 1 -> parity_err one pulse, fifo_count unchanged, code_vector unchanged.
- 0x1C with stop bit 0 -> frame_err pulse; 4 data bits then clock idle TIMEOUT_CYCLES -> frame_err pulse, next full frame 0x1C accepted.
- FIFO_DEPTH=4, 5 frames, no pops -> fifo_count 4, overflow on 5th, code_vector holds 5th byte; 5th frame with pop in push cycle -> no overflow.
- 1-cycle glitches (< FILTER_LEN) on PS2_KBCLK during frame -> no extra events, byte correct; rst_n low mid-frame -> all outputs 0, next frame accepted.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and framing constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic ODD_PARITY = 1'b1;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus run-length deglitch filter for one raw PS/2 pin.
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] run_cnt;

  // Filtered value flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      filt    <= 1'b1;
      run_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == filt) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        filt    <= sync2;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard frame receiver with byte FIFO and scan-code history.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned CODE_BYTES     = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              PS2_KBCLK,
  input  logic                              PS2_KBDAT,
  output logic [8*CODE_BYTES-1:0]           code_vector,
  output logic [7:0]                        byte_data,
  output logic                              byte_valid,
  input  logic                              byte_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic                              overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned VW = 8 * CODE_BYTES;

  logic kbclk_f, kbdat_f, kbclk_f_q, sample_c;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst_n(rst_n), .raw(PS2_KBCLK), .filt(kbclk_f));

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk(clk), .rst_n(rst_n), .raw(PS2_KBDAT), .filt(kbdat_f));

  assign sample_c = kbclk_f_q & ~kbclk_f;

  ps2_state_e    state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          frame_err_c, parity_err_c, accept_c;

  // Deframer next-state logic with inter-edge timeout.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    par_n        = par;
    tmo_n        = '0;
    frame_err_c  = 1'b0;
    parity_err_c = 1'b0;
    accept_c     = 1'b0;
    case (state)
      IDLE: if (sample_c) begin
        if (kbdat_f == START_BIT) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end else begin
          frame_err_c = 1'b1;
        end
      end
      DATA: if (sample_c) begin
        shift_n   = {kbdat_f, shift[7:1]};
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = PARITY;
      end
      PARITY: if (sample_c) begin
        par_n   = kbdat_f;
        state_n = STOP;
      end
      STOP: if (sample_c) begin
        state_n = IDLE;
        if (kbdat_f != STOP_BIT)                frame_err_c  = 1'b1;
        else if ((^{shift, par}) != ODD_PARITY) parity_err_c = 1'b1;
        else                                    accept_c     = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && !sample_c) begin
      if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        state_n     = IDLE;
        frame_err_c = 1'b1;
      end else begin
        tmo_n = tmo + TW'(1);
      end
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW-1:0] wr_addr, rd_addr_n;
  logic          pop_c, full_c, push_c, ovf_c;
  logic [CW-1:0] count_n;
  logic [7:0]    head_n;
  logic [VW-1:0] code_next_c;

  // FIFO control: a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    pop_c     = byte_valid & byte_ready;
    full_c    = (fifo_count == CW'(FIFO_DEPTH));
    push_c    = accept_c & (~full_c | pop_c);
    ovf_c     = accept_c & full_c & ~pop_c;
    rd_ptr_n  = rd_ptr + (AW+1)'(pop_c);
    rd_addr_n = rd_ptr_n[AW-1:0];
    wr_addr   = wr_ptr[AW-1:0];
    count_n   = fifo_count;
    if (push_c && !pop_c)      count_n = fifo_count + CW'(1);
    else if (pop_c && !push_c) count_n = fifo_count - CW'(1);
    if (count_n == '0)                     head_n = 8'h00;
    else if (push_c && wr_addr == rd_addr_n) head_n = shift;
    else                                   head_n = mem[rd_addr_n];
  end

  generate
    if (CODE_BYTES == 1) begin : g_code_one
      assign code_next_c = shift;
    end else begin : g_code_shift
      assign code_next_c = {code_vector[VW-9:0], shift};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      par         <= 1'b0;
      tmo         <= '0;
      kbclk_f_q   <= 1'b1;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overflow    <= 1'b0;
      code_vector <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= 8'h00;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      par         <= par_n;
      tmo         <= tmo_n;
      kbclk_f_q   <= kbclk_f;
      frame_err   <= frame_err_c;
      parity_err  <= parity_err_c;
      overflow    <= ovf_c;
      if (accept_c) code_vector <= code_next_c;
      if (push_c)   wr_ptr <= wr_ptr + (AW+1)'(1);
      rd_ptr      <= rd_ptr_n;
      fifo_count  <= count_n;
      byte_valid  <= (count_n != '0);
      byte_data   <= head_n;
    end
  end

  // Storage array needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_addr] <= shift;
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed scoreboard bench for ps2_rx_fifo: framing, errors, FIFO, glitches, reset.
module tb_ps2_rx_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kbclk = 1'b1;
  logic        kbdat = 1'b1;
  logic        byte_ready = 1'b0;
  logic [15:0] code_vector;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [2:0]  fifo_count;
  logic        frame_err, parity_err, overflow;

  ps2_rx_fifo #(
    .CODE_BYTES(2), .FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .PS2_KBCLK(kbclk), .PS2_KBDAT(kbdat),
    .code_vector(code_vector), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .fifo_count(fifo_count), .frame_err(frame_err),
    .parity_err(parity_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
  int exp_fe = 0, exp_pe = 0, exp_ov = 0;
  logic [7:0]  sb[$];
  logic [15:0] cv_exp = 16'h0000;

  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
    if (overflow)   ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pulses(input string tag);
    chk({tag, "_frame_err"},  32'(fe_cnt), 32'(exp_fe));
    chk({tag, "_parity_err"}, 32'(pe_cnt), 32'(exp_pe));
    chk({tag, "_overflow"},   32'(ov_cnt), 32'(exp_ov));
  endtask

  // One PS/2 bit: data set while clock high, then 8-cycle low, 4-cycle high.
  task automatic send_bit(input logic b, input bit glitch, input bit pop_now);
    logic [7:0] e;
    kbdat = b;
    if (glitch) begin
      @(negedge clk) kbclk = 1'b0;
      @(negedge clk) kbclk = 1'b1;
      repeat (2) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    kbclk = 1'b0;
    if (pop_now) begin
      repeat (6) @(negedge clk);
      e = sb.pop_front();
      chk("pop_at_stop_data", 32'(byte_data), 32'(e));
      byte_ready = 1'b1;
      @(negedge clk) byte_ready = 1'b0;
      @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
    kbclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop_b,
                            input bit pop_stop, input bit glitch);
    logic p;
    p = (~^b) ^ bad_par;
    send_bit(1'b0, glitch, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch, 1'b0);
    send_bit(p, glitch, 1'b0);
    send_bit(stop_b, glitch, pop_stop);
    kbdat = 1'b1;
    if (!stop_b) exp_fe++;
    else if (bad_par) exp_pe++;
    else begin
      cv_exp = {cv_exp[7:0], b};
      if (sb.size() < DEPTH) sb.push_back(b);
      else exp_ov++;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    int t;
    t = 0;
    while (!byte_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid"}, 32'(byte_valid), 32'd1);
    if (byte_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, 32'(byte_data), 32'(e));
      byte_ready = 1'b1;
      @(negedge clk) byte_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_data",  32'(byte_data),  32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_cv",    32'(code_vector), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_pulses("rst");

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("f1_valid", 32'(byte_valid), 32'd1);
    chk("f1_cv_lo", 32'(code_vector[7:0]), 32'h1C);
    chk_pulses("f1");
    pop_check("f1_pop");
    chk("f1_count_after", 32'(fifo_count), 32'd0);

    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("two_count", 32'(fifo_count), 32'd2);
    chk("two_cv", 32'(code_vector), 32'(cv_exp));
    chk("two_cv_abs", 32'(code_vector), 32'hF01C);
    pop_check("two_pop0");
    pop_check("two_pop1");

    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_pulses("par");
    chk("par_count", 32'(fifo_count), 32'd0);
    chk("par_cv", 32'(code_vector), 32'(cv_exp));

    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_pulses("stop");
    chk("stop_count", 32'(fifo_count), 32'd0);

    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i % 2), 1'b0, 1'b0);
    kbdat = 1'b1;
    repeat (TMO + 50) @(negedge clk);
    exp_fe++;
    chk_pulses("tmo");
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("tmo_next_cv", 32'(code_vector), 32'(cv_exp));
    pop_check("tmo_next_pop");

    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_cv", 32'(code_vector), 32'h0405);
    chk_pulses("ovf");
    for (int k = 0; k < 4; k++) pop_check("ovf_drain");

    for (int k = 0; k < 4; k++) send_frame(8'h11 + 8'(k), 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h15, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("popfull_count", 32'(fifo_count), 32'd4);
    chk_pulses("popfull");
    for (int k = 0; k < 4; k++) pop_check("popfull_drain");

    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("glitch_cv", 32'(code_vector), 32'(cv_exp));
    chk_pulses("glitch");
    pop_check("glitch_pop");

    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    kbdat = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_valid", 32'(byte_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_cv",    32'(code_vector), 32'd0);
    chk("mid_rst_data",  32'(byte_data), 32'd0);
    sb.delete();
    cv_exp = 16'h0000;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_pulses("mid_rst");
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_cv", 32'(code_vector), 32'h001C);
    pop_check("post_rst_pop");
    chk_pulses("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
